// File: rtl/index_mem_pkg.sv
// Shared types and constants for the reverse-order frame collector.
package index_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] FILL_VALUE = 8'd100;
    localparam int         COUNT_W    = 5;

endpackage

// File: rtl/index_mem_wr_ptr.sv
// Descending write pointer: starts at the top slot, steps down per accepted byte,
// and returns to the top whenever a frame closes.
module index_mem_wr_ptr #(
    parameter int DEPTH  = 10,
    parameter int LO_IDX = 2,
    parameter int PTR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             frame_end,
    output logic [PTR_W-1:0] ptr,
    output logic             is_last
);

    localparam logic [PTR_W-1:0] TOP_IDX = PTR_W'(LO_IDX + DEPTH - 1);
    localparam logic [PTR_W-1:0] BOT_IDX = PTR_W'(LO_IDX);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = frame_end ? TOP_IDX : ptr_q - PTR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= TOP_IDX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr     = ptr_q;
    assign is_last = (ptr_q == BOT_IDX);

endmodule

// File: rtl/index_mem_fill_model.sv
// Collects a byte frame into an offset-indexed memory, highest index first.
// Optional INDEX_MEM_FILL_DEFAULT_EN presets unwritten entries to FILL_VALUE at frame start.
module index_mem_fill_model
    import index_mem_pkg::*;
#(
    parameter int DEPTH  = 10,
    parameter int LO_IDX = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:8]   in_data,
    input  logic          in_last,
    output logic [15:8]   out_mem_8bit [LO_IDX:LO_IDX+DEPTH-1],
    output logic          out_valid,
    input  logic          out_ack,
    output logic [4:0]    out_count,
    output logic [47:16]  _32bit_out
);

    localparam int HI_IDX = LO_IDX + DEPTH - 1;
    localparam int PTR_W  = $clog2(LO_IDX + DEPTH);

    if (DEPTH > 31 || DEPTH < 4) begin : g_bad_depth
        $error("index_mem_fill_model: DEPTH must lie in 4..31");
    end

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [15:8]        mem_q [LO_IDX:HI_IDX];
    logic [15:8]        mem_d [LO_IDX:HI_IDX];

    logic             accept;
    logic             frame_end;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_is_last;

    assign accept    = in_valid && in_ready_q;
    // The DEPTH-th byte closes the frame whether or not in_last accompanies it.
    assign frame_end = accept && (in_last || wr_is_last);

    index_mem_wr_ptr #(
        .DEPTH  (DEPTH),
        .LO_IDX (LO_IDX),
        .PTR_W  (PTR_W)
    ) u_wr_ptr (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .frame_end (frame_end),
        .ptr       (wr_ptr),
        .is_last   (wr_is_last)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        mem_d       = mem_q;
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
`ifdef INDEX_MEM_FILL_DEFAULT_EN
                    if (state_q == IDLE) begin
                        for (int i = LO_IDX; i <= HI_IDX; i++) mem_d[i] = FILL_VALUE;
                    end
`endif
                    mem_d[wr_ptr] = in_data;
                    count_d       = count_q + COUNT_W'(1);
                    if (frame_end) begin
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            DONE: begin
                if (out_ack) begin
                    state_d     = IDLE;
                    count_d     = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                count_d     = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            // NOTE: the frame memory is a visible output, so it is cleared on reset rather than left undefined.
            for (int i = LO_IDX; i <= HI_IDX; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mem_q       <= mem_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_count    = count_q;
    assign out_mem_8bit = mem_q;
    assign _32bit_out   = {mem_q[LO_IDX], mem_q[LO_IDX+1], mem_q[LO_IDX+2], mem_q[LO_IDX+3]};

endmodule

// File: tb/tb_index_mem_fill_model.sv
// Scoreboard bench for index_mem_fill_model; expectations follow INDEX_MEM_FILL_DEFAULT_EN.
module tb_index_mem_fill_model;

    localparam int DEPTH = 10;
    localparam int LO    = 2;
    localparam int HI    = LO + DEPTH - 1;

`ifdef INDEX_MEM_FILL_DEFAULT_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:8]  in_data;
    logic         in_last;
    logic [15:8]  out_mem_8bit [LO:HI];
    logic         out_valid;
    logic         out_ack;
    logic [4:0]   out_count;
    logic [47:16] w32;

    index_mem_fill_model #(.DEPTH(DEPTH), .LO_IDX(LO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_mem_8bit (out_mem_8bit),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .out_count    (out_count),
        ._32bit_out   (w32)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8*DEPTH-1:0] mem;
        logic [4:0]         count;
        logic [31:0]        w32;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] ref_mem [LO:HI];
    logic [7:0] fb [0:DEPTH-1];
    int         tests_run    = 0;
    int         tests_failed = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference update for a frame of n bytes from fb[], queued for the monitor.
    task automatic push_frame(input int n);
        frame_t f;
        if (FILL_EN) for (int i = LO; i <= HI; i++) ref_mem[i] = 8'd100;
        for (int k = 0; k < n; k++) ref_mem[HI-k] = fb[k];
        for (int i = LO; i <= HI; i++) f.mem[(i-LO)*8 +: 8] = ref_mem[i];
        f.count = 5'(n);
        f.w32   = {ref_mem[LO], ref_mem[LO+1], ref_mem[LO+2], ref_mem[LO+3]};
        exp_q.push_back(f);
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ack();
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        for (int i = LO; i <= HI; i++) check($sformatf("%s_mem%0d", tag, i), 80'(out_mem_8bit[i]), 80'h0);
        check({tag, "_count"}, 80'(out_count), 80'd0);
        check({tag, "_ready"}, 80'(in_ready), 80'd1);
        check({tag, "_valid"}, 80'(out_valid), 80'd0);
    endtask

    // Monitor: one scoreboard comparison set per rising edge of out_valid.
    initial begin
        bit     seen;
        frame_t f;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || out_valid !== 1'b1) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_frame: out_valid rose with no frame expected");
                end else begin
                    f = exp_q.pop_front();
                    for (int i = LO; i <= HI; i++)
                        check($sformatf("sb_mem%0d", i), 80'(out_mem_8bit[i]), 80'(f.mem[(i-LO)*8 +: 8]));
                    check("sb_count", 80'(out_count), 80'(f.count));
                    check("sb_w32", 80'(w32), 80'(f.w32));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_cleared("reset");
        check("reset_w32", 80'(w32), 80'h0);
        for (int i = LO; i <= HI; i++) ref_mem[i] = 8'h00;

        // Full frame, back-to-back, in_last only on the DEPTH-th byte.
        for (int k = 0; k < DEPTH; k++) fb[k] = 8'(k + 1);
        push_frame(DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            send(fb[k], k == DEPTH - 1);
            check($sformatf("full_valid_%0d", k), 80'(out_valid), 80'(k == DEPTH - 1));
        end
        check("full_count", 80'(out_count), 80'd10);
        check("full_w32", 80'(w32), 80'h0A090807);
        check("full_mem11", 80'(out_mem_8bit[11]), 80'h01);
        check("full_mem2", 80'(out_mem_8bit[2]), 80'h0A);

        // Backpressure in DONE.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_ready_%0d", c), 80'(in_ready), 80'd0);
            check($sformatf("bp_valid_%0d", c), 80'(out_valid), 80'd1);
        end
        check("bp_w32", 80'(w32), 80'h0A090807);
        check("bp_mem11", 80'(out_mem_8bit[11]), 80'h01);
        check("bp_count", 80'(out_count), 80'd10);
        out_ack = 1'b1;
        check("ack_cycle_ready", 80'(in_ready), 80'd0);
        @(posedge clk);
        #1;
        out_ack  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("post_ack_ready", 80'(in_ready), 80'd1);
        check("post_ack_valid", 80'(out_valid), 80'd0);
        check("post_ack_count", 80'(out_count), 80'd0);
        check("post_ack_mem_hold", 80'(w32), 80'h0A090807);

        // Short frame on top of the full frame.
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
        push_frame(3);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        check("short_count", 80'(out_count), 80'd3);
        check("short_mem9", 80'(out_mem_8bit[9]), 80'h33);
        check("short_mem8", 80'(out_mem_8bit[8]), FILL_EN ? 80'h64 : 80'h04);
        check("short_w32", 80'(w32), FILL_EN ? 80'h64646464 : 80'h0A090807);
        ack();

        // Gapped frame with in_last high during idle gaps, and a stray out_ack in FILL.
        for (int k = 0; k < DEPTH; k++) fb[k] = 8'(k + 1);
        push_frame(DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            send(fb[k], k == DEPTH - 1);
            if (k < DEPTH - 1) begin
                in_last = 1'b1;
                out_ack = (k == 1);
                @(posedge clk);
                #1;
                in_last = 1'b0;
                out_ack = 1'b0;
                check($sformatf("gap_valid_%0d", k), 80'(out_valid), 80'd0);
                check($sformatf("gap_count_%0d", k), 80'(out_count), 80'(k + 1));
            end
        end
        check("gap_valid_end", 80'(out_valid), 80'd1);
        check("gap_w32", 80'(w32), 80'h0A090807);
        check("gap_mem11", 80'(out_mem_8bit[11]), 80'h01);
        ack();

        // Reset in the middle of a frame.
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_cleared("midrst");
        for (int i = LO; i <= HI; i++) ref_mem[i] = 8'h00;
        fb[0] = 8'h5A;
        push_frame(1);
        send(8'h5A, 1'b1);
        check("midrst_mem11", 80'(out_mem_8bit[11]), 80'h5A);
        check("midrst_count", 80'(out_count), 80'd1);
        ack();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 80'(exp_q.size()), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
